spdu_route_ctrl: RTL and testbench
==================================

# spdu_route_ctrl

Route controller for the 4-input / 4-output `spdu` switch element. It accepts per-input packet requests (valid, destination bit, last-beat flag) and arbitrates each output between the two inputs that can reach it, using round-robin with packet lock. It drives the `spdu` select lines `d0`–`d3`, returns per-input grants, and emits per-output valid flags aligned with the switch's registered outputs. It sits beside the `spdu` instance at the parent level and does not instantiate it.

## Interface
- `TIMEOUT`, default 0: stall-timeout in cycles for a granted input with `req` low; 0 disables the timeout.
- `clk`  in  1  clock, shared with `spdu`.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-input request / beat-valid; bit i belongs to `in{i}`.
- `dst`  in  4  per-input destination: 0 = lower output of the input's pair, 1 = upper output. Stable while `req[i]` is high.
- `last`  in  4  per-input last beat of packet; meaningful only when `req[i]` is high.
- `gnt`  out  4  per-input grant, registered.
- `sel`  out  4  select bits to `spdu` `d0`–`d3`, registered.
- `out_vld`  out  4  valid for `spdu` `out0`–`out3`, aligned with the switch's registered data.
- `busy`  out  4  per-output locked flag.
- `err`  out  4  per-output one-cycle timeout pulse.

## Operation
- **Pair mapping.**
  - Output 0: `in0` when `sel[0]`=0, `in1` when `sel[0]`=1.
  - Output 2: same, using `sel[2]`.
  - Output 1: `in2` when `sel[1]`=0, `in3` when `sel[1]`=1.
  - Output 3: same, using `sel[3]`.
  - Inputs 0/1 reach outputs 0 (`dst`=0) or 2 (`dst`=1).
  - Inputs 2/3 reach outputs 1 (`dst`=0) or 3 (`dst`=1).
  - No illegal destination exists.
- **Per-output FSM: IDLE / BUSY.**
  - IDLE:
    - Candidates are the pair inputs with `req`=1 and a matching `dst`.
    - With one candidate, that input wins.
    - With two candidates, the input indicated by the round-robin pointer `rr[k]` wins.
    - At the clock edge: state becomes BUSY, `owner` is set to the winner, `sel[k]` is set to the winner's index within the pair, and `gnt[owner]` is set to 1.
  - BUSY:
    - A beat is any cycle with `req[owner]` and `gnt[owner]` both high.
    - A beat with `last`=1 causes, at the edge: IDLE, `gnt` cleared, `rr[k]` pointed at the other input of the pair.
    - `sel[k]` holds its last value while IDLE.
- **Independence.**
  - Two inputs of one pair targeting different outputs are both granted in the same cycle.
  - All four outputs can be BUSY simultaneously.
- **Stalls.** `req[owner]` low while BUSY is a stall: the grant is held and no beat occurs.
- **Timeout** (`TIMEOUT`>0):
  - Per-output counter of consecutive stall cycles; it clears on any beat.
  - When it reaches `TIMEOUT`: forced release exactly as on `last`, and `err[k]` pulses in the following cycle.
- **`out_vld[k]`** is the registered value of "beat on output k", so it is high in the cycle after the beat. This matches `spdu` capturing `in{owner}` at the beat edge.
- **`busy[k]`** is 1 when output k is BUSY.
- **Reset values:** `gnt`=0, `sel`=0, `out_vld`=0, `busy`=0, `err`=0, all FSMs IDLE, all `rr`=0 (lower input favoured), timeout counters 0.
- **Reset mid-packet:** an asynchronous assert clears everything immediately. The packet is abandoned and no `err` pulse is produced.

## Timing
- Request to grant: a request in cycle t (output IDLE) gives `gnt` and `sel` in cycle t+1. The first beat can be cycle t+1.
- Beat to data: a beat in cycle b gives `spdu` `out_k` and `out_vld[k]` valid in cycle b+1.
- Release: a `last` beat in cycle b drops `gnt` in cycle b+1; output k is IDLE in b+1 and arbitrates in b+1.
  - A waiting requester is therefore granted in b+2, a one-cycle gap.
  - The releasing input may re-request, but `rr` favours its peer.
- Single-beat packet: `req`+`last` in the grant cycle gives exactly one beat.
- Simultaneous `last` and timeout expiry in the same cycle: treated as a normal `last`, with no `err`.

## Structure
- **Package `spdu_ctrl_pkg`:**
  - `NUM_PORTS`=4;
  - state enum `{IDLE, BUSY}`;
  - functions `out_of(input, dst)` and `pair_base(output)`.
- **Sub-module `spdu_out_arb`:**
  - two-requester round-robin arbiter with lock, FSM and timeout counter;
  - four instances;
  - the top level does pair fan-in and the `out_vld` register.

## Test plan
- **Reset:** assert `reset`=0 mid-traffic → `gnt`, `sel`, `out_vld`, `busy` and `err` are all 0 within the same cycle, with no pulse after deassert.
- **Single beat:** `req[1]`=1, `dst[1]`=1, `last[1]`=1 at cycle 0 →
  - `gnt`=4'b0010 and `sel[2]`=1 at cycle 1;
  - `out_vld`=4'b0100 at cycle 2;
  - `gnt`=0 at cycle 2.
- **Contention:** `in0` and `in1` both `dst`=0, 3-beat packets →
  - `in0` is granted cycles 1–3;
  - `in1` is granted from cycle 5 with `sel[0]`=1;
  - a repeat contention afterwards grants `in0` first.
- **Parallel:** all `req`=1 with `dst`=4'b1010 → `gnt`=4'b1111 and `sel`=4'b1100 at cycle 1, and `busy`=4'b1111.
- **Stall:** the owner drops `req` for 2 cycles mid-packet → `gnt` held, `out_vld` low for exactly 2 cycles, then the packet completes normally.
- **Timeout:** `TIMEOUT`=4, owner stalls 4 cycles → `gnt` drops, `err[k]` pulses for 1 cycle, the output returns to IDLE, and the peer's pending request is granted on the following cycle.

Source files
------------

// File: rtl/spdu_route_ctrl_pkg.sv
// Shared types and pair-mapping helpers for the spdu route controller.
// Inputs 0/1 feed outputs 0/2 and inputs 2/3 feed outputs 1/3; dst picks the upper output.
package spdu_ctrl_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Output reached by an input for a given destination bit.
  function automatic logic [1:0] out_of(input logic [1:0] in_idx, input logic dst);
    return {dst, in_idx[1]};
  endfunction

  // Lower input of the pair that can reach an output.
  function automatic logic [1:0] pair_base(input logic [1:0] out_idx);
    return {out_idx[0], 1'b0};
  endfunction

endpackage

// File: rtl/spdu_route_ctrl_if.sv
// Request/grant bundle between packet sources and the spdu route controller.
interface spdu_route_ctrl_if
  import spdu_ctrl_pkg::*;
  ();

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] dst;
  logic [NUM_PORTS-1:0] last;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] out_vld;
  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] err;

  modport master (
    output req, dst, last,
    input  gnt, sel, out_vld, busy, err
  );

  modport slave (
    input  req, dst, last,
    output gnt, sel, out_vld, busy, err
  );

endinterface

// File: rtl/spdu_route_ctrl_out_arb.sv
// Per-output two-requester round-robin arbiter with packet lock and stall timeout.
// Index 0/1 on every port is the lower/upper input of the output's pair.
module spdu_out_arb
  import spdu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_cand,
  input  logic [1:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_gnt,
  output logic       o_sel,
  output logic       o_busy,
  output logic       o_beat,
  output logic       o_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    r_state, w_state_nxt;
  logic          r_sel, w_sel_nxt;
  logic          r_rr, w_rr_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;
  logic          w_own_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rr    <= w_rr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_own_req   = i_req[r_sel];
    o_beat      = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_cand != '0) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = (i_cand == 2'b11) ? r_rr : i_cand[1];
          w_gnt_nxt   = w_sel_nxt ? 2'b10 : 2'b01;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (w_own_req) begin
          o_beat    = 1'b1;
          w_cnt_nxt = '0;
          if (i_last[r_sel]) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_rr_nxt    = ~r_sel;
          end
        end else if ((TIMEOUT > 0) && (r_cnt == LIM)) begin
          // Expiry only happens on a stall cycle, so it can never coincide with a last beat.
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_rr_nxt    = ~r_sel;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_gnt  = r_gnt;
  assign o_sel  = r_sel;
  assign o_busy = (r_state == BUSY);
  assign o_err  = r_err;

endmodule

// File: rtl/spdu_route_ctrl.sv
// Route controller for the 4x4 spdu switch: pair fan-in, four output arbiters,
// grant merge and the out_vld register aligned with spdu's registered data.
module spdu_route_ctrl
  import spdu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  spdu_route_ctrl_if.slave  bus
);

  logic [1:0]           w_cand     [NUM_PORTS];
  logic [1:0]           w_req_p    [NUM_PORTS];
  logic [1:0]           w_last_p   [NUM_PORTS];
  logic [1:0]           w_arb_gnt  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt;
  logic [NUM_PORTS-1:0] w_sel;
  logic [NUM_PORTS-1:0] w_busy;
  logic [NUM_PORTS-1:0] w_beat;
  logic [NUM_PORTS-1:0] w_err;
  logic [NUM_PORTS-1:0] r_out_vld;

  always_comb begin
    logic [1:0] w_idx;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_req_p[k]  = '0;
      w_last_p[k] = '0;
      w_cand[k]   = '0;
      for (int unsigned j = 0; j < 2; j++) begin
        w_idx          = pair_base(2'(k)) + 2'(j);
        w_req_p[k][j]  = bus.req[w_idx];
        w_last_p[k][j] = bus.last[w_idx];
        w_cand[k][j]   = bus.req[w_idx] & (out_of(w_idx, bus.dst[w_idx]) == 2'(k));
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    spdu_out_arb #(
      .TIMEOUT(TIMEOUT)
    ) u_arb (
      .clk    (clk),
      .rst_n  (reset),
      .i_cand (w_cand[g]),
      .i_req  (w_req_p[g]),
      .i_last (w_last_p[g]),
      .o_gnt  (w_arb_gnt[g]),
      .o_sel  (w_sel[g]),
      .o_busy (w_busy[g]),
      .o_beat (w_beat[g]),
      .o_err  (w_err[g])
    );
  end

  // An input holds at most one output at a time, so OR-merging the per-output grants is exact.
  always_comb begin
    w_gnt = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        if (w_arb_gnt[k][j]) begin
          w_gnt[pair_base(2'(k)) + 2'(j)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_vld <= '0;
    end else begin
      r_out_vld <= w_beat;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.sel     = w_sel;
  assign bus.out_vld = r_out_vld;
  assign bus.busy    = w_busy;
  assign bus.err     = w_err;

endmodule

// File: tb/tb_spdu_route_ctrl.sv
// Bench for spdu_route_ctrl: directed vector table, reset corner case, then random
// traffic against a packet-level reference model.
module tb_spdu_route_ctrl;
  import spdu_ctrl_pkg::*;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spdu_route_ctrl_if bus ();

  spdu_route_ctrl #(
    .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req, dst, last;
    logic [3:0] gnt, sel, vld, busy, err;
  } vec_t;
  vec_t tv[$];

  function automatic void add(logic [3:0] rq, logic [3:0] ds, logic [3:0] ls,
                              logic [3:0] g, logic [3:0] s, logic [3:0] v,
                              logic [3:0] b, logic [3:0] e);
    vec_t t;
    t.req = rq; t.dst = ds; t.last = ls;
    t.gnt = g; t.sel = s; t.vld = v; t.busy = b; t.err = e;
    tv.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] s,
                           input logic [3:0] v, input logic [3:0] b, input logic [3:0] e);
    check({tag, ".gnt"},     bus.gnt,     g);
    check({tag, ".sel"},     bus.sel,     s);
    check({tag, ".out_vld"}, bus.out_vld, v);
    check({tag, ".busy"},    bus.busy,    b);
    check({tag, ".err"},     bus.err,     e);
  endtask

  // Packet-level reference: owner per output (-1 = free), favoured input, stall run length.
  int         m_own[4];
  int         m_rr[4];
  int         m_stall[4];
  logic [3:0] m_sel, m_vld, m_err;

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_own[k]   = -1;
      m_rr[k]    = 2 * (k % 2);
      m_stall[k] = 0;
    end
    m_sel = '0; m_vld = '0; m_err = '0;
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] g = '0;
    for (int k = 0; k < 4; k++) if (m_own[k] >= 0) g[m_own[k]] = 1'b1;
    return g;
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] b = '0;
    for (int k = 0; k < 4; k++) b[k] = (m_own[k] >= 0);
    return b;
  endfunction

  function automatic void m_step(logic [3:0] rq, logic [3:0] ds, logic [3:0] ls);
    for (int k = 0; k < 4; k++) begin
      int  lo   = 2 * (k % 2);
      int  want = k / 2;
      bit  c0, c1;
      int  win, o;
      m_vld[k] = 1'b0;
      m_err[k] = 1'b0;
      if (m_own[k] < 0) begin
        c0  = rq[lo]     && (int'(ds[lo])     == want);
        c1  = rq[lo + 1] && (int'(ds[lo + 1]) == want);
        win = c0 && c1 ? m_rr[k] : c0 ? lo : c1 ? lo + 1 : -1;
        if (win >= 0) begin
          m_own[k]   = win;
          m_sel[k]   = (win % 2 == 1);
          m_stall[k] = 0;
        end
      end else begin
        o = m_own[k];
        if (rq[o]) begin
          m_vld[k]   = 1'b1;
          m_stall[k] = 0;
          if (ls[o]) begin
            m_own[k] = -1;
            m_rr[k]  = o ^ 1;
          end
        end else begin
          m_stall[k]++;
          if (TO > 0 && m_stall[k] >= int'(TO)) begin
            m_own[k]   = -1;
            m_rr[k]    = o ^ 1;
            m_stall[k] = 0;
            m_err[k]   = 1'b1;
          end
        end
      end
    end
  endfunction

  initial begin
    logic [3:0] rq, ds, ls, g;

    // single beat / contention / parallel / stall / timeout, starting from reset
    add(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1111, 4'b1010, 4'b0000, 4'b1111, 4'b1100, 4'b0000, 4'b1111, 4'b0000);
    add(4'b1111, 4'b1010, 4'b1111, 4'b0000, 4'b1100, 4'b1111, 4'b0000, 4'b0000);
    add(4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0000, 4'b0010, 4'b0000);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0000, 4'b0010, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0000, 4'b0010, 4'b0000);
    add(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1100, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b1100, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0011, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0010, 4'b0011, 4'b0000, 4'b0010, 4'b1100, 4'b0000, 4'b0100, 4'b0000);
    add(4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b1100, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000);

    reset    = 1'b0;
    bus.req  = '0;
    bus.dst  = '0;
    bus.last = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b1;

    foreach (tv[i]) begin
      bus.req  = tv[i].req;
      bus.dst  = tv[i].dst;
      bus.last = tv[i].last;
      @(posedge clk);
      #1;
      check_all($sformatf("tbl%0d", i), tv[i].gnt, tv[i].sel, tv[i].vld, tv[i].busy, tv[i].err);
    end

    // Asynchronous reset in the middle of four locked packets, plus one stalled owner.
    bus.req  = 4'b1111;
    bus.dst  = 4'b1010;
    bus.last = 4'b0000;
    @(posedge clk); #1;
    check_all("mid_pre", 4'b1111, 4'b1100, 4'b0000, 4'b1111, 4'b0000);
    bus.req = 4'b1110;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.req = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_all("post_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    m_reset();
    rq = '0; ds = '0; ls = '0;
    for (int c = 0; c < 3000; c++) begin
      g = m_gnt();
      for (int i = 0; i < 4; i++) begin
        rq[i] = ($urandom_range(0, 9) < 7);
        if (!rq[i] && !g[i]) ds[i] = 1'($urandom_range(0, 1));
        ls[i] = ($urandom_range(0, 2) == 0);
      end
      bus.req  = rq;
      bus.dst  = ds;
      bus.last = ls;
      m_step(rq, ds, ls);
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", c), m_gnt(), m_sel, m_vld, m_busy(), m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
